// File: rtl/stim_gen_pkg.sv
// stim_pkg: run-state encoding, LFSR taps and per-operand seed derivation
package stim_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
  localparam logic [63:0] LFSR_TAPS = 64'hD800_0000_0000_0000;
  function automatic logic [63:0] seed_for(input logic [1:0] k, input logic [63:0] seed);
    logic [63:0] r;
    r = (seed << (16 * k)) | (seed >> (64 - 16 * k));
    return r == '0 ? 64'h1 : r;
  endfunction
endpackage

// File: rtl/stim_gen_lfsr64.sv
// lfsr64: 64-bit Galois LFSR with load priority over step
module lfsr64 import stim_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [63:0] seed,
  input  logic        step,
  output logic [63:0] q
);
  logic [63:0] q_q, q_d;
  always_comb q_d = load ? seed : step ? (q_q >> 1) ^ (q_q[0] ? LFSR_TAPS : '0) : q_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q_q <= '0;
    else q_q <= q_d;
  assign q = q_q;
endmodule

// File: rtl/stim_gen.sv
// stim_gen: seeded four-operand vector source with a latency-aligned check strobe
module stim_gen import stim_pkg::*; #(
  parameter int unsigned DATAWIDTH   = 64,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] NUM_VECTORS = 32'd1024,
  parameter logic [63:0] SEED        = 64'h1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [DATAWIDTH-1:0] a,
  output logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] c,
  output logic [DATAWIDTH-1:0] d,
  output logic                 check_valid,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          vec_count
);
  state_e state_q, state_d;
  logic [31:0] vec_q, vec_d;
  logic [3:0] drain_q, drain_d;
  logic [LATENCY-1:0] dl_q, dl_d;
  logic busy_q, done_q;
  logic [63:0] lfsr_q [4];
  logic load, issue;
  assign issue = state_q == RUN;
  assign load = start && (state_q == IDLE || state_q == DONE);
  for (genvar i = 0; i < 4; i++) begin : g_lfsr
    lfsr64 u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .seed (seed_for(2'(i), SEED)),
      .step (issue),
      .q    (lfsr_q[i])
    );
  end
  always_comb begin
    state_d = state_q;
    vec_d = vec_q;
    drain_d = drain_q;
    dl_d = LATENCY'({dl_q, issue});
    unique case (state_q)
      IDLE, DONE: if (start) begin
        state_d = RUN;
        vec_d = '0;
      end
      RUN: begin
        vec_d = vec_q == '1 ? vec_q : vec_q + 32'd1;
        if (vec_q == NUM_VECTORS - 32'd1) begin
          state_d = DRAIN;
          drain_d = 4'(LATENCY - 1);
        end
      end
      DRAIN: if (drain_q == '0) state_d = DONE;
        else drain_d = drain_q - 4'd1;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      vec_q <= '0;
      drain_q <= '0;
      dl_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q <= vec_d;
      drain_q <= drain_d;
      dl_q <= dl_d;
      busy_q <= state_d == RUN || state_d == DRAIN;
      done_q <= state_d == DONE;
    end
  // Operands are forced to zero outside RUN so idle buses never look like stimulus.
  assign a = issue ? lfsr_q[0][DATAWIDTH-1:0] : '0;
  assign b = issue ? lfsr_q[1][DATAWIDTH-1:0] : '0;
  assign c = issue ? lfsr_q[2][DATAWIDTH-1:0] : '0;
  assign d = issue ? lfsr_q[3][DATAWIDTH-1:0] : '0;
  assign check_valid = dl_q[LATENCY-1];
  assign busy = busy_q;
  assign done = done_q;
  assign vec_count = vec_q;
endmodule

// File: tb/tb_stim_gen.sv
// tb_stim_gen: directed scoreboard bench for stim_gen across several parameter sets
module tb_stim_gen;
  typedef struct {
    logic [63:0] a, b, c, d;
  } vec_t;
  localparam logic [63:0] A_T [4] = '{64'h1, 64'hD800_0000_0000_0000, 64'h6C00_0000_0000_0000, 64'h3600_0000_0000_0000};
  localparam logic [63:0] B_T [4] = '{64'h1_0000, 64'h8000, 64'h4000, 64'h2000};
  localparam logic [63:0] C_T [4] = '{64'h1_0000_0000, 64'h8000_0000, 64'h4000_0000, 64'h2000_0000};
  localparam logic [63:0] D_T [4] = '{64'h0001_0000_0000_0000, 64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000, 64'h0000_2000_0000_0000};
  logic clk = 0;
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  vec_t exp_q[$];
  logic rst_a = 1, start_a = 0, rst_m = 1, start_m = 0, rst_s = 1, start_s = 0;
  logic [63:0] a_a, b_a, c_a, d_a, a_m, b_m, c_m, d_m;
  logic cv_a, busy_a, done_a, cv_m, busy_m, done_m;
  logic [31:0] vc_a, vc_m;
  logic [7:0] s_a [3], s_b [3], s_c [3], s_d [3];
  logic cv_s [3], busy_s [3], done_s [3];
  logic [31:0] vc_s [3];
  stim_gen #(.NUM_VECTORS(32'd4)) u_a (
    .clk(clk), .rst(rst_a), .start(start_a), .a(a_a), .b(b_a), .c(c_a), .d(d_a),
    .check_valid(cv_a), .busy(busy_a), .done(done_a), .vec_count(vc_a));
  stim_gen #(.NUM_VECTORS(32'd16)) u_m (
    .clk(clk), .rst(rst_m), .start(start_m), .a(a_m), .b(b_m), .c(c_m), .d(d_m),
    .check_valid(cv_m), .busy(busy_m), .done(done_m), .vec_count(vc_m));
  stim_gen #(.DATAWIDTH(8), .LATENCY(1), .NUM_VECTORS(32'd10)) u_l1 (
    .clk(clk), .rst(rst_s), .start(start_s), .a(s_a[0]), .b(s_b[0]), .c(s_c[0]), .d(s_d[0]),
    .check_valid(cv_s[0]), .busy(busy_s[0]), .done(done_s[0]), .vec_count(vc_s[0]));
  stim_gen #(.DATAWIDTH(8), .LATENCY(7), .NUM_VECTORS(32'd10)) u_l7 (
    .clk(clk), .rst(rst_s), .start(start_s), .a(s_a[1]), .b(s_b[1]), .c(s_c[1]), .d(s_d[1]),
    .check_valid(cv_s[1]), .busy(busy_s[1]), .done(done_s[1]), .vec_count(vc_s[1]));
  stim_gen #(.DATAWIDTH(8), .SEED(64'h0), .NUM_VECTORS(32'd2)) u_w (
    .clk(clk), .rst(rst_s), .start(start_s), .a(s_a[2]), .b(s_b[2]), .c(s_c[2]), .d(s_d[2]),
    .check_valid(cv_s[2]), .busy(busy_s[2]), .done(done_s[2]), .vec_count(vc_s[2]));
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask
  // Monitor: every RUN cycle of u_a presents one vector, popped against the queue.
  always @(negedge clk) begin : mon
    vec_t e;
    bit ok;
    if (rst_a && busy_a && vc_a < 32'd4) begin
      ok = exp_q.size() != 0;
      check("sb_nonempty", 64'(ok), 64'd1);
      if (ok) begin
        e = exp_q.pop_front();
        check("sb_a", a_a, e.a);
        check("sb_b", b_a, e.b);
        check("sb_c", c_a, e.c);
        check("sb_d", d_a, e.d);
      end
    end
  end
  task automatic run_a(input bit poke);
    vec_t v;
    int cnt = 0;
    for (int i = 0; i < 4; i++) begin
      v.a = A_T[i]; v.b = B_T[i]; v.c = C_T[i]; v.d = D_T[i];
      exp_q.push_back(v);
    end
    @(negedge clk) start_a = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      start_a = poke && k == 1;
      cnt += int'(cv_a);
      check("cv_a", 64'(cv_a), 64'(k >= 2 && k <= 5));
      check("busy_a", 64'(busy_a), 64'(k < 6));
      check("done_a", 64'(done_a), 64'(k >= 6));
    end
    start_a = 0;
    check("strobes_a", 64'(cnt), 64'd4);
    check("vec_count_a", 64'(vc_a), 64'd4);
    check("sb_drained", 64'(exp_q.size()), 64'd0);
  endtask
  task automatic seq_a();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("idle_a", 64'(|{a_a, b_a, c_a, d_a, cv_a, busy_a, done_a, vc_a}), 64'd0);
    end
    run_a(0);
    run_a(1);
  endtask
  task automatic seq_m();
    @(negedge clk) start_m = 1;
    @(negedge clk) start_m = 0;
    check("m_v0", a_m, 64'h1);
    repeat (5) @(negedge clk);
    check("m_v5", a_m, 64'h0D80_0000_0000_0000);
    check("m_cv_before", 64'(cv_m), 64'd1);
    #1 rst_m = 0;
    #1;
    check("m_rst_ops", 64'(|{a_m, b_m, c_m, d_m}), 64'd0);
    check("m_rst_flags", 64'({cv_m, busy_m, done_m}), 64'd0);
    check("m_rst_count", 64'(vc_m), 64'd0);
    #1 rst_m = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check("m_quiet", 64'({cv_m, busy_m}), 64'd0);
    end
    start_m = 1;
    @(negedge clk) start_m = 0;
    check("m_restart_v0", a_m, 64'h1);
    @(negedge clk);
    check("m_restart_v1", a_m, 64'hD800_0000_0000_0000);
  endtask
  task automatic seq_s();
    int first [2] = '{-1, -1};
    int cnt [2] = '{0, 0};
    @(negedge clk) start_s = 1;
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      start_s = 0;
      for (int j = 0; j < 2; j++) begin
        if (cv_s[j] && first[j] < 0) first[j] = k;
        cnt[j] += int'(cv_s[j]);
      end
      if (k == 0) begin
        check("w_a0", 64'(s_a[2]), 64'h01);
        check("w_b0", 64'(s_b[2]), 64'h01);
      end
      if (k == 1) check("w_a1", 64'(s_a[2]), 64'h00);
      if (k == 10 || k == 11) check("l1_done", 64'(done_s[0]), 64'(k == 11));
      if (k == 16 || k == 17) check("l7_done", 64'(done_s[1]), 64'(k == 17));
    end
    check("l1_first", 64'(first[0]), 64'd1);
    check("l7_first", 64'(first[1]), 64'd7);
    check("l1_count", 64'(cnt[0]), 64'd10);
    check("l7_count", 64'(cnt[1]), 64'd10);
    check("l7_vec_count", 64'(vc_s[1]), 64'd10);
  endtask
  initial begin
    #12 {rst_a, rst_m, rst_s} = 3'b000;
    #1;
    check("rst_async", 64'(|{a_a, cv_a, busy_a, done_a, vc_a, a_m, busy_m}), 64'd0);
    @(posedge clk) #1 {rst_a, rst_m, rst_s} = 3'b111;
    fork
      seq_a();
      seq_m();
      seq_s();
    join
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
